// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bundle: writeback and
// multi-cycle write requests, decode hazard probes, rf port.
interface regfile_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          wb_valid;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          wb_stall;

  logic          mc_valid;
  logic          mc_ready;
  logic [4:0]    mc_addr;
  logic [31:0]   mc_data;

  logic [4:0]    rd_addr1;
  logic [4:0]    rd_addr2;
  logic          pend_hit1;
  logic          pend_hit2;

  logic          rf_reg_write;
  logic [4:0]    rf_write_addr;
  logic [31:0]   rf_write_data;
  logic [CW-1:0] fifo_count;

  modport master (
    output wb_valid, wb_addr, wb_data,
    input  wb_stall,
    output mc_valid, mc_addr, mc_data,
    input  mc_ready,
    output rd_addr1, rd_addr2,
    input  pend_hit1, pend_hit2,
    input  rf_reg_write, rf_write_addr, rf_write_data,
    input  fifo_count
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    output wb_stall,
    input  mc_valid, mc_addr, mc_data,
    output mc_ready,
    input  rd_addr1, rd_addr2,
    output pend_hit1, pend_hit2,
    output rf_reg_write, rf_write_addr, rf_write_data,
    output fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (A)
// and a FIFO of multi-cycle results (B) with anti-starvation.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [4:0]    fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          a_cand;
  logic          b_cand;
  logic          override;
  logic          grant_a;
  logic          grant_b;
  logic          accept;
  logic          enq;
  logic [4:0]    grant_addr;
  logic [31:0]   grant_data;
  logic          hit1;
  logic          hit2;
  logic [AW-1:0] idx;

  assign a_cand   = bus.wb_valid && (bus.wb_addr != 5'd0);
  assign b_cand   = (count != '0);
  assign override = b_cand && (starve_cnt == LIMIT);
  assign grant_b  = b_cand && (override || !a_cand);
  assign grant_a  = a_cand && !override;

  assign bus.wb_stall   = !rst && a_cand && override;
  assign bus.mc_ready   = !rst && (count < FULL);
  assign bus.fifo_count = count;

  // Reg-0 offers complete the handshake but are dropped.
  assign accept = bus.mc_valid && bus.mc_ready;
  assign enq    = accept && (bus.mc_addr != 5'd0);

  assign grant_addr = grant_b ? fifo_addr[head] : bus.wb_addr;
  assign grant_data = grant_b ? fifo_data[head] : bus.wb_data;

  // Scan live FIFO slots and the output stage for hazards.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = head + AW'(k);
      if (CW'(k) < count) begin
        if (fifo_addr[idx] == bus.rd_addr1) hit1 = 1'b1;
        if (fifo_addr[idx] == bus.rd_addr2) hit2 = 1'b1;
      end
    end
    if (bus.rf_reg_write) begin
      if (bus.rf_write_addr == bus.rd_addr1) hit1 = 1'b1;
      if (bus.rf_write_addr == bus.rd_addr2) hit2 = 1'b1;
    end
  end

  assign bus.pend_hit1 = !rst && (bus.rd_addr1 != 5'd0) && hit1;
  assign bus.pend_hit2 = !rst && (bus.rd_addr2 != 5'd0) && hit2;

  // FIFO payload storage; no reset needed, validity is count.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[tail] <= bus.mc_addr;
      fifo_data[tail] <= bus.mc_data;
    end
  end

  // Pointers, occupancy and the B starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq)     tail <= tail + AW'(1);
      if (grant_b) head <= head + AW'(1);
      unique case ({enq, grant_b})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Only a B loss to A counts; the override caps it.
      if (b_cand && a_cand && !override)
        starve_cnt <= starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
    end
  end

  // Registered write stage towards the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rf_reg_write  <= 1'b0;
      bus.rf_write_addr <= 5'd0;
      bus.rf_write_data <= 32'd0;
    end else if (grant_a || grant_b) begin
      bus.rf_reg_write  <= 1'b1;
      bus.rf_write_addr <= grant_addr;
      bus.rf_write_data <= grant_data;
    end else begin
      bus.rf_reg_write  <= 1'b0;
    end
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writers: the pipeline writeback stage (requester A) and multi-cycle units such as mult/div or uncached loads (requester B). Requester B writes are buffered in a small in-order FIFO. The block uses fixed priority for A, with a starvation override for B. It drives a registered write stage into `register_file`, and reports pending-write hits so decode can stall reads of registers that are still in flight.

## Interface
- `FIFO_DEPTH`, 4: requester B buffer entries (power of 2, ≥2)
- `STARVE_LIMIT`, 8: consecutive cycles B may lose to A before an override
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `wb_valid` in 1: A write request this cycle
- `wb_addr` in 5: A destination register
- `wb_data` in 32: A write data
- `wb_stall` out 1: combinational; A is not granted this cycle and must hold its request
- `mc_valid` in 1: B write offer
- `mc_ready` out 1: B offer accepted when `mc_valid && mc_ready` at a rising edge
- `mc_addr` in 5: B destination register
- `mc_data` in 32: B write data
- `rd_addr1`, `rd_addr2` in 5 each: decode read addresses
- `pend_hit1`, `pend_hit2` out 1 each: combinational; a pending write targets the matching read address
- `rf_reg_write` out 1: registered write enable to the register file
- `rf_write_addr` out 5: registered write address
- `rf_write_data` out 32: registered write data
- `fifo_count` out clog2(FIFO_DEPTH+1): number of valid B entries

## Operation
- Reg 0 filtering:
  - A with `wb_addr==0` counts as no request and is never stalled.
  - B with `mc_addr==0` is accepted (handshake completes) but is not stored.
- Candidates each cycle:
  - A: `wb_valid && wb_addr!=0`.
  - B: `fifo_count!=0`, using the head entry only.
- Arbitration, first matching rule wins:
  1. B candidate and `starve_cnt==STARVE_LIMIT`: grant B, `starve_cnt←0`. `wb_stall=1` if A is a candidate.
  2. A candidate: grant A. If B is a candidate, `starve_cnt←starve_cnt+1`, saturating at `STARVE_LIMIT`.
  3. B candidate: grant B, `starve_cnt←0`.
  4. Otherwise: no grant.
- `starve_cnt` is forced to 0 whenever the FIFO is empty.
- Output stage:
  - On a grant, the next edge loads `rf_reg_write=1` with the granted addr/data.
  - With no grant, `rf_reg_write←0` and addr/data hold their previous values.
- FIFO:
  - In order, circular pointers with wrap modulo `FIFO_DEPTH`.
  - `mc_ready = !rst && fifo_count<FIFO_DEPTH`. No full-bypass: a full FIFO refuses an offer even if it dequeues in the same cycle.
  - Enqueue and dequeue in the same cycle leave `fifo_count` unchanged.
  - A newly enqueued entry is eligible for grant no earlier than the next cycle.
- Pending hits: `pend_hitN=1` when `rd_addrN!=0` and it equals either:
  - the address of any valid FIFO entry, or
  - `rf_write_addr` while `rf_reg_write=1`.
- A and B writes to the same register are not reordered by this block. Decode uses `pend_hit` to avoid issuing such a conflicting A write.

## Timing
- Reset values (asynchronous):
  - `rf_reg_write=0`, `rf_write_addr=0`, `rf_write_data=0`.
  - FIFO empty, `fifo_count=0`, `starve_cnt=0`, pointers 0.
  - While `rst=1`: `mc_ready=0`, `wb_stall=0`, `pend_hit1=0`, `pend_hit2=0`.
- A latency: a request granted at edge N makes `rf_reg_write` high during cycle N→N+1. The register file captures the data at edge N+1, so it is readable from cycle N+1 onward.
- B latency, empty FIFO: accepted at edge N, granted at N+1 (if not blocked), written at N+2.
- Minimum B throughput: one entry per `STARVE_LIMIT+1` cycles under a continuous A stream.
- Reset mid-operation: pending FIFO entries and any in-flight output-stage write are discarded. No write reaches the register file after `rst` rises.
- `wb_stall` and `pend_hit*` depend only on current state and inputs. There is no path from `wb_stall` to `mc_ready`.

## Test plan
- **A only:** `wb_valid=1`, r5=0xDEADBEEF for 1 cycle → one-cycle `rf_reg_write` pulse with addr 5 / data 0xDEADBEEF; reg 5 then reads 0xDEADBEEF and `wb_stall` stays 0.
- **B ordering and pend_hit:** push r10=0xCAFECAFE then r11=0x1 on consecutive cycles with A idle → written in order on consecutive cycles. With `rd_addr1=10`, `pend_hit1=1` from the enqueue edge until the edge the register file captures r10, then 0.
- **Starvation override:** FIFO holds r12=100 and A streams r7 continuously → A granted 8 cycles. On the 9th cycle `wb_stall=1` and r12=100 is written. A resumes the following cycle and `starve_cnt` returns to 0.
- **Full:** A streaming, push r1..r5 → 4 accepted, `fifo_count=4`, `mc_ready=0` with r5 held. After the override dequeues r1, r5 is accepted next.
- **Reg 0:** A writes r0=0x12345678 while B offers r0=0xFFFFFFFF → no `rf_reg_write` pulse, `fifo_count` stays 0, B handshake completes, r0 reads 0, `wb_stall=0`.
- **Reset mid-operation:** 3 entries queued and `rf_reg_write=1` → assert `rst` asynchronously: `rf_reg_write=0` and `fifo_count=0` immediately, none of the queued registers change, and `mc_ready=1` on the first cycle after release.
